// File: rtl/bus_responder.sv
// Single-port word memory behind a valid/ready bus with programmable wait states.
// Each accepted request produces exactly one ready pulse; a held valid is parked in RELEASE.
module bus_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned WAIT_STATES  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_vaild,
    output logic        bus_ready,
    output logic        bus_busy,
    input  logic        bus_write_enable,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_data_write,
    output logic [31:0] bus_data_read
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic                  commit_c;
    logic                  eff_we_c;
    logic [DATA_W-1:0]     eff_addr_c;
    logic [DATA_W-1:0]     eff_wdata_c;
    logic [DATA_W-1:0]     offset_c;
    logic                  in_range_c;
    logic [ADDR_WIDTH-1:0] idx_c;

    // Next-state, capture and read-data logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus_vaild) begin
                    we_d    = bus_write_enable;
                    addr_d  = bus_address;
                    wdata_d = bus_data_write;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d = S_RESPOND;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESPOND: begin
                state_d = bus_vaild ? S_RELEASE : S_IDLE;
            end
            S_RELEASE: begin
                if (!bus_vaild) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // With zero wait states the commit edge is also the accept edge, so use live inputs there
        eff_we_c    = (state_q == S_IDLE) ? bus_write_enable : we_q;
        eff_addr_c  = (state_q == S_IDLE) ? bus_address      : addr_q;
        eff_wdata_c = (state_q == S_IDLE) ? bus_data_write   : wdata_q;

        offset_c   = eff_addr_c - BASE_ADDRESS;
        in_range_c = (eff_addr_c >= BASE_ADDRESS) && ((offset_c >> (ADDR_WIDTH + 2)) == '0);
        idx_c      = offset_c[ADDR_WIDTH+1:2];

        commit_c = (state_d == S_RESPOND) && (state_q != S_RESPOND);
        if (commit_c && !eff_we_c) begin
            rdata_d = in_range_c ? mem_q[idx_c] : 32'hFFFF_FFFF;
        end

        ready_d = (state_d == S_RESPOND);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Array contents survive reset; a reset edge also suppresses any pending commit
    always_ff @(posedge clock) begin
        if (reset && commit_c && eff_we_c && in_range_c) begin
            mem_q[idx_c] <= eff_wdata_c;
        end
    end

    assign bus_ready     = ready_q;
    assign bus_busy      = busy_q;
    assign bus_data_read = rdata_q;

endmodule

// File: tb/tb_bus_responder.sv
// Randomized bench for bus_responder: three instances with different bases and wait states,
// checked against a word-array model of the memory and handshake timing.
module tb_bus_responder;

    localparam int NDUT  = 3;
    localparam int DEPTH = 256;
    localparam int NWORD = 16;

    localparam logic [31:0] B0 = 32'h0000_1000;
    localparam logic [31:0] B1 = 32'h4000_0000;
    localparam logic [31:0] B2 = 32'h0000_0000;
    localparam int W0 = 1;
    localparam int W1 = 0;
    localparam int W2 = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        vld  [NDUT];
    logic        we   [NDUT];
    logic [31:0] addr [NDUT];
    logic [31:0] wd   [NDUT];
    logic [31:0] rd   [NDUT];
    logic        rdy  [NDUT];
    logic        busy [NDUT];

    logic [31:0] mem_m   [NDUT][DEPTH];
    logic [31:0] last_rd [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    bus_responder #(.BASE_ADDRESS(B0), .ADDR_WIDTH(8), .WAIT_STATES(W0)) u_dut0 (
        .clock(clock), .reset(reset), .bus_vaild(vld[0]), .bus_ready(rdy[0]), .bus_busy(busy[0]),
        .bus_write_enable(we[0]), .bus_address(addr[0]), .bus_data_write(wd[0]), .bus_data_read(rd[0]));
    bus_responder #(.BASE_ADDRESS(B1), .ADDR_WIDTH(8), .WAIT_STATES(W1)) u_dut1 (
        .clock(clock), .reset(reset), .bus_vaild(vld[1]), .bus_ready(rdy[1]), .bus_busy(busy[1]),
        .bus_write_enable(we[1]), .bus_address(addr[1]), .bus_data_write(wd[1]), .bus_data_read(rd[1]));
    bus_responder #(.BASE_ADDRESS(B2), .ADDR_WIDTH(8), .WAIT_STATES(W2)) u_dut2 (
        .clock(clock), .reset(reset), .bus_vaild(vld[2]), .bus_ready(rdy[2]), .bus_busy(busy[2]),
        .bus_write_enable(we[2]), .bus_address(addr[2]), .bus_data_write(wd[2]), .bus_data_read(rd[2]));

    function automatic logic [31:0] base_of(input int d);
        case (d)
            0:       return B0;
            1:       return B1;
            default: return B2;
        endcase
    endfunction

    function automatic int ws_of(input int d);
        case (d)
            0:       return W0;
            1:       return W1;
            default: return W2;
        endcase
    endfunction

    // Word index of a byte address, or -1 when it falls outside the 1 KiB window
    function automatic int word_of(input int d, input logic [31:0] a);
        logic [31:0] b;
        logic [31:0] off;
        b = base_of(d);
        if (a < b) return -1;
        off = a - b;
        if (off >= 32'd1024) return -1;
        return int'(off / 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            chk({tag, " rdy"}, 32'(rdy[d]), 32'd0);
            chk({tag, " busy"}, 32'(busy[d]), 32'd0);
            chk({tag, " rd"}, rd[d], last_rd[d]);
        end
    endtask

    // One transaction: valid is seen high at 'hold' consecutive edges starting with the accept edge
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] data,
                       input int hold, input bit scramble, input string tag);
        int ws;
        int idx;
        int last_busy;
        logic [31:0] exp;
        ws  = ws_of(d);
        idx = word_of(d, a);
        last_busy = (hold > ws + 1) ? hold : ws + 1;
        @(negedge clock);
        vld[d] = 1'b1; we[d] = w; addr[d] = a; wd[d] = data;
        @(posedge clock);
        for (int n = 1; n <= last_busy + 1; n++) begin
            @(negedge clock);
            chk({tag, " rdy"}, 32'(rdy[d]), 32'(n == ws + 1));
            chk({tag, " busy"}, 32'(busy[d]), 32'(n <= last_busy));
            if (n == ws + 1) begin
                if (w) begin
                    if (idx >= 0) mem_m[d][idx] = data;
                    chk({tag, " rd kept"}, rd[d], last_rd[d]);
                end else begin
                    exp = (idx >= 0) ? mem_m[d][idx] : 32'hFFFF_FFFF;
                    chk({tag, " rdata"}, rd[d], exp);
                    last_rd[d] = exp;
                end
            end
            if (n >= hold) vld[d] = 1'b0;
            if (scramble) begin
                addr[d] = $urandom;
                wd[d]   = $urandom;
            end
        end
    endtask

    // Start a write and pull reset low at the edge ending cycle at_n, before RESPOND is entered
    task automatic reset_mid(input int d, input logic [31:0] a, input logic [31:0] data, input int at_n);
        @(negedge clock);
        vld[d] = 1'b1; we[d] = 1'b1; addr[d] = a; wd[d] = data;
        @(posedge clock);
        for (int n = 1; n <= at_n; n++) begin
            @(negedge clock);
            vld[d] = 1'b0;
            chk("rstmid rdy before", 32'(rdy[d]), 32'd0);
            chk("rstmid busy before", 32'(busy[d]), 32'd1);
        end
        reset = 1'b0;
        @(negedge clock);
        for (int k = 0; k < NDUT; k++) last_rd[k] = 32'h0;
        check_idle("rstmid");
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check_idle("rstmid after");
        end
    endtask

    initial begin
        int d;
        bit w;
        logic [31:0] a;
        logic [31:0] b;
        reset = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            vld[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'h0; wd[k] = 32'h0; last_rd[k] = 32'h0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_idle("reset");
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check_idle("idle");
        end

        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < NWORD; i++)
                txn(k, 1'b1, base_of(k) + 32'(4 * i), $urandom, 1, 1'b0, "init");

        txn(0, 1'b1, B0 + 32'd8, 32'h1234_5678, 1, 1'b0, "wr basic");
        txn(0, 1'b0, B0 + 32'd8, 32'h0, 1, 1'b0, "rd basic");
        txn(1, 1'b0, B1 + 32'd12, 32'h0, 1, 1'b0, "rd zero wait");
        txn(1, 1'b1, B1 + 32'd13, 32'h0BAD_F00D, 1, 1'b0, "wr zero wait");
        txn(1, 1'b0, B1 + 32'd12, 32'h0, 1, 1'b0, "rd after wr");
        for (int k = 0; k < NDUT; k++) txn(k, 1'b0, base_of(k) + 32'd8, 32'h0, 10, 1'b0, "held");

        for (int k = 0; k < NDUT; k++) begin
            txn(k, 1'b0, base_of(k) + 32'd1024, 32'h0, 1, 1'b0, "oor rd");
            txn(k, 1'b1, base_of(k) + 32'd1024, 32'hDEAD_BEEF, 1, 1'b0, "oor wr");
            txn(k, 1'b0, base_of(k), 32'h0, 1, 1'b0, "word0 intact");
        end
        txn(0, 1'b0, B0 - 32'd4, 32'h0, 1, 1'b0, "below base");

        reset_mid(0, B0 + 32'd4, 32'hCAFE_F00D, 1);
        txn(0, 1'b0, B0 + 32'd4, 32'h0, 1, 1'b0, "rd after abort");
        reset_mid(2, B2 + 32'd4, 32'hCAFE_F00D, 3);
        txn(2, 1'b0, B2 + 32'd4, 32'h0, 1, 1'b0, "rd after abort ws3");

        txn(0, 1'b1, B0 + 32'd20, 32'hA5A5_0001, 1, 1'b1, "scramble wr");
        txn(0, 1'b0, B0 + 32'd20, 32'h0, 1, 1'b1, "scramble rd");
        txn(2, 1'b1, B2 + 32'd24, 32'h5A5A_0002, 2, 1'b1, "scramble wr ws3");
        txn(2, 1'b0, B2 + 32'd24, 32'h0, 1, 1'b0, "scramble rd ws3");

        for (int it = 0; it < 300; it++) begin
            d = int'($urandom_range(0, NDUT - 1));
            w = 1'($urandom_range(0, 1));
            b = base_of(d);
            if ($urandom_range(0, 7) == 0) begin
                if (b != 0 && $urandom_range(0, 1) == 1) a = b - 32'(4 * $urandom_range(1, 64));
                else a = b + 32'd1024 + 32'($urandom_range(0, 4000));
            end else begin
                a = b + 32'(4 * $urandom_range(0, NWORD - 1)) + 32'($urandom_range(0, 3));
            end
            txn(d, w, a, $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : 1,
                1'($urandom_range(0, 1)), "random");
        end

        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < NWORD; i++)
                txn(k, 1'b0, base_of(k) + 32'(4 * i), 32'h0, 1, 1'b0, "final sweep");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h0000_0000: byte address of word 0.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: word-index width, so depth is 2**ADDR_WIDTH 32-bit words.
REQ-003 SHALL have parameter WAIT_STATES, default 1, legal range 0..15: extra cycles inserted before the response.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset; low at a rising clock edge resets the block.
REQ-006 SHALL have port bus_vaild, input, 1 bit: the initiator's request is valid.
REQ-007 SHALL have port bus_ready, output, 1 bit: one-cycle response pulse.
REQ-008 SHALL have port bus_busy, output, 1 bit: a transaction is in progress.
REQ-009 SHALL have port bus_write_enable, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port bus_address, input, 32 bits: byte address.
REQ-011 SHALL have port bus_data_write, input, 32 bits: write data.
REQ-012 SHALL have port bus_data_read, output, 32 bits: read data.

Function
REQ-013 SHALL implement states IDLE, WAIT, RESPOND and RELEASE, plus a 4-bit wait counter.
REQ-014 In IDLE with bus_vaild=1, SHALL capture address, write_enable and write data at the edge, then:
- go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0;
- otherwise go to RESPOND.
REQ-015 In WAIT, SHALL decrement the counter each cycle and go to RESPOND on the edge where counter==0.
REQ-016 On the edge entering RESPOND, SHALL:
- commit a captured write to the array;
- for a captured read, register the array word into bus_data_read.
REQ-017 bus_ready SHALL be 1 exactly while in RESPOND, a single cycle; latency from accept edge to ready is WAIT_STATES+1 cycles.
REQ-018 From RESPOND, SHALL go to IDLE if bus_vaild=0, else to RELEASE.
REQ-019 RELEASE SHALL go to IDLE when bus_vaild=0, so a held bus_vaild never starts a second transaction.
REQ-020 bus_busy SHALL be 1 in every state except IDLE.
REQ-021 bus_data_read SHALL hold its value until the next read commit; writes SHALL NOT change it.
REQ-022 Address decode:
- in range when BASE_ADDRESS <= bus_address < BASE_ADDRESS + 4*2**ADDR_WIDTH;
- word index = (bus_address - BASE_ADDRESS)[ADDR_WIDTH+1:2];
- bits [1:0] ignored.
REQ-023 An out-of-range read SHALL return 32'hFFFF_FFFF; an out-of-range write SHALL be discarded; both SHALL complete the handshake with normal timing.
REQ-024 Inputs SHALL be sampled only at the accept edge; changes to address or data during WAIT or RESPOND SHALL have no effect.
REQ-025 If bus_vaild drops during WAIT, the transaction SHALL still complete, including the write commit and the ready pulse.
REQ-026 A read to the same word as the immediately preceding write SHALL return the newly written data.

Reset
REQ-027 With reset=0 at an edge, SHALL set: state IDLE, counter 0, bus_ready 0, bus_busy 0, bus_data_read 32'h0.
REQ-028 Reset SHALL NOT clear array contents.
REQ-029 Reset asserted before the RESPOND-entry edge SHALL abort the transaction with no write committed and no ready pulse.
REQ-030 reset=1 with no bus_vaild SHALL leave all outputs at their reset values.

Verification
REQ-031 Read, WAIT_STATES=1: after reset, write 32'h1234_5678 at BASE+8, then read BASE+8 -> ready pulses 2 cycles after the accept edge, bus_data_read=32'h1234_5678.
REQ-032 Zero wait: WAIT_STATES=0, read accepted at edge k -> ready high in cycle k+1 only, busy high for that same single cycle.
REQ-033 Held valid: bus_vaild held high for 10 cycles -> exactly one ready pulse, busy stays high until valid drops, then IDLE next edge.
REQ-034 Out of range: read BASE+4*256 -> 32'hFFFF_FFFF with normal timing; write 32'hDEAD_BEEF there, then read BASE+0 -> word 0 unchanged.
REQ-035 Reset mid-transaction: reset=0 during WAIT of a write of 32'hCAFE_F00D to BASE+4 -> no ready pulse, outputs at reset values, later read of BASE+4 returns the prior contents.
REQ-036 Input stability: change bus_address and bus_data_write during WAIT -> the originally captured address and data are used.
